// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and default widths for the byte-pair serializer.
`default_nettype none

package serializer_pkg;

   localparam int DATA_W = 8;
   localparam int GAP_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_A = 2'd1,
      SEND_B = 2'd2,
      GAP    = 2'd3
   } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, serial-out shift register; sbit is always the bit on the wire.
`default_nettype none

module piso_shift_reg #(
   parameter int DATA_W    = serializer_pkg::DATA_W,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] pdata,
   output logic              sbit
);

   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] sr_d;

   // Zero fill means a fully shifted register reads back as 0.
   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = pdata;
      end else if (shift) begin
         sr_d = MSB_FIRST ? {sr_q[DATA_W-2:0], 1'b0} : {1'b0, sr_q[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign sbit = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];

endmodule

`default_nettype wire

// File: rtl/byte_pair_serializer.sv
// byte_pair_serializer: sends an accepted (d1, d2) pair as one 2*DATA_W-bit serial frame,
// followed by GAP_CYCLES idle cycles (legal range 0..15).
`default_nettype none

module byte_pair_serializer #(
   parameter int DATA_W     = serializer_pkg::DATA_W,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   output logic              sout,
   output logic              sout_valid,
   output logic              frame_start,
   output logic              busy
);

   import serializer_pkg::*;

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GW    = serializer_pkg::GAP_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   ser_state_t       state_q;
   ser_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [GW-1:0]    gap_q;
   logic [GW-1:0]    gap_d;

   logic accept;
   logic load;
   logic shift_a;
   logic shift_b;
   logic sbit_a;
   logic sbit_b;

   logic sout_valid_q;
   logic frame_start_q;
   logic busy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      accept  = 1'b0;
      load    = 1'b0;
      shift_a = 1'b0;
      shift_b = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               load    = 1'b1;
               cnt_d   = '0;
               state_d = SEND_A;
            end
         end
         SEND_A: begin
            shift_a = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = SEND_B;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SEND_B: begin
            shift_b = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               gap_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         gap_q         <= '0;
         sout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         gap_q         <= gap_d;
         sout_valid_q  <= (state_d == SEND_A) || (state_d == SEND_B);
         frame_start_q <= accept;
         busy_q        <= (state_d != IDLE);
      end
   end

   // Both channels load at the accept edge, so later d1/d2 changes cannot reach the frame.
   piso_shift_reg #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_ch1 (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift_a),
      .pdata (d1),
      .sbit  (sbit_a)
   );

   piso_shift_reg #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_ch2 (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift_b),
      .pdata (d2),
      .sbit  (sbit_b)
   );

   always_comb begin
      sout = 1'b0;
      if (state_q == SEND_A) begin
         sout = sbit_a;
      end else if (state_q == SEND_B) begin
         sout = sbit_b;
      end
   end

   assign in_ready    = (state_q == IDLE) && !rst;
   assign sout_valid  = sout_valid_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_pair_serializer.sv
// tb_byte_pair_serializer: three configurations driven with directed and random pairs,
// checked by a queue scoreboard fed from a frame-level reference model.
`default_nettype none

module tb_byte_pair_serializer;

   localparam int NCFG = 3;

   typedef struct {
      bit b;
      int cyc;
   } exp_t;

   logic clk;
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int g, input string nm, input logic act, input logic exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL cfg%0d %s: got %b, required %b (cycle %0d)", g, nm, act, exp_v, cyc);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam bit MF = (g != 1);
      localparam int GC = (g == 0) ? 1 : ((g == 1) ? 3 : 0);

      logic       rst;
      logic       in_valid;
      logic       in_ready;
      logic [7:0] d1;
      logic [7:0] d2;
      logic       sout;
      logic       sout_valid;
      logic       frame_start;
      logic       busy;

      exp_t q[$];
      int   a_last  = -1000;
      int   acc_cnt = 0;
      bit   inited  = 1'b0;
      bit   done    = 1'b0;

      byte_pair_serializer #(
         .DATA_W     (8),
         .MSB_FIRST  (MF),
         .GAP_CYCLES (GC)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .in_valid    (in_valid),
         .in_ready    (in_ready),
         .d1          (d1),
         .d2          (d2),
         .sout        (sout),
         .sout_valid  (sout_valid),
         .frame_start (frame_start),
         .busy        (busy)
      );

      // Reference model: a frame accepted at edge a owns cycles a..a+15 for bits
      // and a..a+15+GC for busy; the next edge decision uses the inputs seen now.
      always @(negedge clk) begin
         int         k;
         bit         ev;
         bit         eb;
         exp_t       e;
         logic [7:0] w;
         int         sh;
         k = cyc;
         if (inited) begin
            ev = (k >= a_last) && (k <= a_last + 15);
            eb = (k >= a_last) && (k <= a_last + 15 + GC);
            chk(g, "sout_valid", sout_valid, ev);
            chk(g, "busy", busy, eb);
            chk(g, "in_ready", in_ready, !rst && !eb);
            chk(g, "frame_start", frame_start, (k == a_last));
            if (!ev) chk(g, "sout_idle", sout, 1'b0);
         end
         if (rst) begin
            while (q.size() > 0 && q[$].cyc >= k + 1) void'(q.pop_back());
            a_last = -1000;
            inited = 1'b1;
         end else if (inited && in_valid && (k > a_last + 15 + GC)) begin
            a_last = k + 1;
            acc_cnt++;
            for (int i = 0; i < 16; i++) begin
               w     = (i < 8) ? d1 : d2;
               sh    = MF ? 7 - (i % 8) : (i % 8);
               e.b   = w[sh];
               e.cyc = k + 1 + i;
               q.push_back(e);
            end
         end
      end

      // Monitor: consumes one expected bit for every cycle the DUT marks valid.
      always @(negedge clk) begin
         exp_t e;
         if (inited && sout_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL cfg%0d sout_data: got bit %b at cycle %0d, required no frame bit", g, sout, cyc);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc || e.b !== sout) begin
                  errors++;
                  $display("FAIL cfg%0d sout_data: got %b at cycle %0d, required %b at cycle %0d",
                           g, sout, cyc, e.b, e.cyc);
               end
            end
         end
      end

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [7:0] a, input logic [7:0] b);
         int start;
         int n;
         start    = acc_cnt;
         n        = 0;
         d1       = a;
         d2       = b;
         in_valid = 1'b1;
         while (acc_cnt == start && n < 200) begin
            step();
            n++;
         end
         checks++;
         if (acc_cnt == start) begin
            errors++;
            $display("FAIL cfg%0d accept_timeout: got no accept after %0d cycles, required accept", g, n);
         end
      endtask

      task automatic garble(input int n);
         in_valid = 1'b0;
         for (int i = 0; i < n; i++) begin
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            step();
         end
      endtask

      initial begin
         rst      = 1'b1;
         in_valid = 1'b0;
         d1       = 8'h00;
         d2       = 8'h00;
         repeat (3) step();
         rst = 1'b0;
         step();

         send(8'hA5, 8'h3C);
         garble(25);
         send(8'h01, 8'h80);
         garble(25);

         send(8'hFF, 8'h00);
         send(8'h0F, 8'hF0);
         garble(40);

         // Abort on bit 5 of d1, then a clean frame.
         send(8'h5A, 8'hC3);
         garble(5);
         rst = 1'b1;
         step();
         rst = 1'b0;
         send(8'h12, 8'h34);
         garble(40);

         // Reset and in_valid on the same edge: reset must win.
         d1       = 8'h77;
         d2       = 8'h88;
         in_valid = 1'b1;
         rst      = 1'b1;
         step();
         rst = 1'b0;
         garble(5);

         for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            d1       = 8'($urandom);
            d2       = 8'($urandom);
            rst      = ($urandom_range(0, 149) == 0);
            step();
         end
         rst = 1'b0;
         garble(40);

         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL cfg%0d leftover: got %0d undelivered bits, required 0", g, q.size());
         end
         done = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done)) begin
         errors++;
         $display("FAIL run_timeout: got unfinished stimulus after %0d cycles, required completion", n);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
